// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, turns taken EX branches into
// flushes plus a PC redirect (held while the PC is stalled), and tracks stall stats.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  output logic [5:0]       stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pc_redirect,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             timeout
);

  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0] RUN_SET = RUN_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {RUN, PEND} state_t;

  state_t             state, state_nxt;
  logic [31:0]        target_q, target_nxt;
  logic [5:0]         stall_raw;
  logic               accept;
  logic [RUN_W-1:0]   run_cnt;

  always_comb begin
    stall_raw = 6'b000000;
    if (stallreq_mem)     stall_raw = 6'b011111;
    else if (stallreq_ex) stall_raw = 6'b001111;
    else if (stallreq_id) stall_raw = 6'b000111;
    else if (stallreq_if) stall_raw = 6'b000011;
  end

  // A branch only counts when EX is advancing; a frozen EX re-presents it next cycle.
  assign stall  = rst ? stall_raw : 6'b000000;
  assign accept = rst & branch_flag_i & ~stall_raw[3];

  always_comb begin
    state_nxt   = state;
    target_nxt  = target_q;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    pc_redirect = 1'b0;
    new_pc      = 32'h0;
    if (rst) begin
      case (state)
        RUN: begin
          if (accept) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (!stall_raw[0]) begin
              pc_redirect = 1'b1;
              new_pc      = branch_target_i;
            end else begin
              target_nxt = branch_target_i;
              state_nxt  = PEND;
            end
          end
        end
        PEND: begin
          // Keep flushing IF/ID so wrong-path fetches die until the PC takes the target.
          pc_redirect = 1'b1;
          flush_ifid  = 1'b1;
          new_pc      = target_q;
          if (accept) begin
            flush_idex = 1'b1;
            target_nxt = branch_target_i;
            new_pc     = branch_target_i;
          end
          if (!stall_raw[0]) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      target_q     <= 32'h0;
      stall_cycles <= '0;
      flush_count  <= '0;
      run_cnt      <= '0;
      timeout      <= 1'b0;
    end else begin
      state    <= state_nxt;
      target_q <= target_nxt;
      if (accept) flush_count <= flush_count + CNT_W'(1);
      if (|stall_raw) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
        if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);
        if (run_cnt >= RUN_SET) timeout <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule
